// File: rtl/spi_burst_master.sv
// spi_burst_master: SPI mode-3 master that sends one command byte followed by a
// burst of 0..MAX_BYTES data bytes (read or write). SPC half-period = CLK_DIV clks.
// Build option: define SPI_BURST_MS_BIT_EN to send the slave auto-increment flag
// (ms = more than one data byte) in command bit 6 instead of addr[6].
module spi_burst_master #(
  parameter int MAX_BYTES = 12,
  parameter int CLK_DIV   = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           rw,
  input  logic [6:0]                     addr,
  input  logic [$clog2(MAX_BYTES+1)-1:0] nbytes,
  input  logic [8*MAX_BYTES-1:0]         wdata,
  input  logic                           SDO,
  output logic                           SPC,
  output logic                           CS,
  output logic                           SDI,
  output logic [8*MAX_BYTES-1:0]         rdata,
  output logic                           busy,
  output logic                           done
);
  localparam int NBW = $clog2(MAX_BYTES+1);
  localparam int DW  = 8*MAX_BYTES;
  localparam int TW  = DW + 8;
  localparam int BCW = $clog2(TW);
  localparam int PW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]  PH_LAST = PW'(CLK_DIV - 1);
  localparam logic [NBW-1:0] NB_MAX  = NBW'(MAX_BYTES);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t         state, state_nxt;
  logic [PW-1:0]  phase, phase_nxt;
  logic [BCW-1:0] bit_cnt, bit_nxt;
  logic [BCW-1:0] last_bit, last_nxt;
  logic           half, half_nxt;
  logic           rw_lat, rw_nxt;
  logic [TW-1:0]  tx, tx_nxt, tx_load;
  logic           spc_nxt, cs_nxt, sdi_nxt, busy_nxt, done_nxt;
  logic [DW-1:0]  rdata_nxt;
  logic [NBW-1:0] eff_n;
  logic [7:0]     cmd;
  logic [BCW-1:0] data_idx, rx_pos;
  logic           phase_end;

  // Data bit j of byte k lands at rdata[8k+7-j]: flip the in-byte index.
  assign data_idx  = bit_cnt - BCW'(8);
  assign rx_pos    = {data_idx[BCW-1:3], ~data_idx[2:0]};
  assign phase_end = (phase == PH_LAST);

  // Clamp the byte count and build the MSB-first transmit image for an accept.
  always_comb begin
    eff_n = (nbytes > NB_MAX) ? NB_MAX : nbytes;
`ifdef SPI_BURST_MS_BIT_EN
    cmd = {rw, (eff_n > NBW'(1)), addr[5:0]};
`else
    cmd = {rw, addr};
`endif
    tx_load = '0;
    tx_load[TW-1 -: 8] = cmd;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (!rw) tx_load[DW-1-8*k -: 8] = wdata[8*k +: 8];
    end
  end

  // Next state, counters and next registered output values.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    bit_nxt   = bit_cnt;
    half_nxt  = half;
    last_nxt  = last_bit;
    rw_nxt    = rw_lat;
    tx_nxt    = tx;
    spc_nxt   = SPC;
    cs_nxt    = CS;
    sdi_nxt   = SDI;
    rdata_nxt = rdata;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETUP;
          phase_nxt = '0;
          rw_nxt    = rw;
          last_nxt  = BCW'({eff_n, 3'b111});
          tx_nxt    = tx_load;
          cs_nxt    = 1'b0;
          spc_nxt   = 1'b1;
          sdi_nxt   = 1'b0;
          busy_nxt  = 1'b1;
          rdata_nxt = '0;
        end
      end
      SETUP: begin
        if (phase_end) begin
          state_nxt = SHIFT;
          phase_nxt = '0;
          half_nxt  = 1'b0;
          bit_nxt   = '0;
          spc_nxt   = 1'b0;
          sdi_nxt   = tx[TW-1];
          tx_nxt    = {tx[TW-2:0], 1'b0};
        end else begin
          phase_nxt = phase + PW'(1);
        end
      end
      SHIFT: begin
        if (!phase_end) begin
          phase_nxt = phase + PW'(1);
        end else begin
          phase_nxt = '0;
          if (!half) begin
            // Rising SPC: the slave's bit is captured here (data phase of reads only).
            half_nxt = 1'b1;
            spc_nxt  = 1'b1;
            if (rw_lat && (bit_cnt[BCW-1:3] != '0)) rdata_nxt[rx_pos] = SDO;
          end else if (bit_cnt == last_bit) begin
            state_nxt = HOLD;
            sdi_nxt   = 1'b0;
          end else begin
            bit_nxt  = bit_cnt + BCW'(1);
            half_nxt = 1'b0;
            spc_nxt  = 1'b0;
            sdi_nxt  = tx[TW-1];
            tx_nxt   = {tx[TW-2:0], 1'b0};
          end
        end
      end
      HOLD: begin
        if (phase_end) begin
          state_nxt = DONE;
          phase_nxt = '0;
          cs_nxt    = 1'b1;
          done_nxt  = 1'b1;
        end else begin
          phase_nxt = phase + PW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and registered outputs; reset returns the pins to idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      phase   <= '0;
      bit_cnt <= '0;
      half    <= 1'b0;
      SPC     <= 1'b1;
      CS      <= 1'b1;
      SDI     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
    end else begin
      state   <= state_nxt;
      phase   <= phase_nxt;
      bit_cnt <= bit_nxt;
      half    <= half_nxt;
      SPC     <= spc_nxt;
      CS      <= cs_nxt;
      SDI     <= sdi_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      rdata   <= rdata_nxt;
    end
  end

  // Per-frame parameters; reloaded on every accept, so they carry no reset.
  always_ff @(posedge clk) begin
    rw_lat   <= rw_nxt;
    last_bit <= last_nxt;
    tx       <= tx_nxt;
  end

endmodule

// File: tb/tb_spi_burst_master.sv
// tb_spi_burst_master: random and directed frames against a timing-formula model.
module tb_spi_burst_master;
  localparam int MAXB = 12;
  localparam int H    = 3;
  localparam int DW   = 8*MAXB;
  localparam int NBW  = $clog2(MAXB+1);
  localparam int TB   = 8*(MAXB+1);

  logic           clk = 1'b0;
  logic           reset, start, rw, SDO;
  logic [6:0]     addr;
  logic [NBW-1:0] nbytes;
  logic [DW-1:0]  wdata;
  logic           SPC, CS, SDI, busy, done;
  logic [DW-1:0]  rdata;

  spi_burst_master #(.MAX_BYTES(MAXB), .CLK_DIV(H)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr),
    .nbytes(nbytes), .wdata(wdata), .SDO(SDO), .SPC(SPC), .CS(CS),
    .SDI(SDI), .rdata(rdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Model of the current frame: accept edge t0, bit count, bits sent and bits the slave returns.
  int            t0 = -1;
  int            nbits = 0;
  bit            f_rw = 1'b0;
  bit            txb [TB];
  bit            rxb [TB];
  logic [DW-1:0] pre_rdata = '0;

  int passes = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  int             fall_cnt = 0;
  logic [127:0]   sdi_cap = '0;
  int             done_cyc = -1;
  logic           spc_prev = 1'b1;

  function automatic int frame_len();
    return (2*nbits + 2)*H;
  endfunction

  function automatic logic [DW-1:0] model_rdata(int c);
    logic [DW-1:0] r;
    r = '0;
    if (f_rw) begin
      for (int b = 8; b < nbits; b++)
        if (c >= 2*H + 2*b*H) r[8*((b-8)/8) + 7 - ((b-8)%8)] = rxb[b];
    end
    return r;
  endfunction

  task automatic chk_bit(string name, logic act, logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s cyc=%0d got %b expected %b", name, cyc, act, exp);
  endtask

  task automatic chk_vec(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s cyc=%0d got %h expected %h", name, cyc, act, exp);
  endtask

  task automatic chk_int(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Compare every cycle on the falling edge.
  initial begin
    int c;
    logic e_spc, e_cs, e_sdi, e_busy, e_done;
    logic [DW-1:0] e_rd;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        c = cyc - t0;
        e_spc = 1'b1; e_cs = 1'b1; e_sdi = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        e_rd = pre_rdata;
        if (t0 >= 0 && c >= 0) begin
          e_rd = model_rdata(c);
          if (c < frame_len()) begin
            e_cs = 1'b0;
            e_busy = 1'b1;
            if (c >= H && c < (2*nbits + 1)*H) begin
              e_spc = (((c - H) % (2*H)) >= H);
              e_sdi = txb[(c - H)/(2*H)];
            end
          end else if (c == frame_len()) begin
            e_busy = 1'b1;
            e_done = 1'b1;
          end
        end
        chk_bit("spc", SPC, e_spc);
        chk_bit("cs", CS, e_cs);
        chk_bit("sdi", SDI, e_sdi);
        chk_bit("busy", busy, e_busy);
        chk_bit("done", done, e_done);
        chk_vec("rdata", rdata, e_rd);
        if (spc_prev === 1'b1 && SPC === 1'b0) begin
          fall_cnt++;
          sdi_cap = {sdi_cap[126:0], SDI};
        end
        spc_prev = SPC;
        if (done === 1'b1) done_cyc = cyc;
      end
    end
  end

  // Slave: presents its bit for the whole of each bit period, noise otherwise.
  initial begin
    int c;
    SDO = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      c = cyc - t0;
      if (t0 >= 0 && c >= H && c < (2*nbits + 1)*H) SDO = rxb[(c - H)/(2*H)];
      else SDO = 1'($urandom);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(int target);
    int guard;
    guard = 0;
    while (cyc < target && guard < 20000) begin
      tick();
      guard++;
    end
  endtask

  task automatic scramble();
    rw = 1'($urandom);
    addr = 7'($urandom);
    nbytes = NBW'($urandom);
    for (int k = 0; k < MAXB; k++) wdata[8*k +: 8] = 8'($urandom);
  endtask

  // Drive a request that the DUT accepts at the next edge, and load the model.
  task automatic launch(bit r, logic [6:0] a, int nb, logic [DW-1:0] wd, bit fix_rx, logic [7:0] rx0);
    int eff;
    logic [7:0] cmd;
    eff = (nb > MAXB) ? MAXB : nb;
    if (t0 >= 0) pre_rdata = model_rdata(1 << 30);
    cmd = {r, a};
`ifdef SPI_BURST_MS_BIT_EN
    cmd = {r, (eff > 1), a[5:0]};
`endif
    nbits = 8*(1 + eff);
    f_rw = r;
    for (int i = 0; i < 8; i++) txb[i] = cmd[7-i];
    for (int b = 8; b < nbits; b++) txb[b] = r ? 1'b0 : wd[8*((b-8)/8) + 7 - ((b-8)%8)];
    for (int b = 0; b < TB; b++) rxb[b] = 1'($urandom);
    if (fix_rx) for (int j = 0; j < 8; j++) rxb[8+j] = rx0[7-j];
    rw = r; addr = a; nbytes = NBW'(nb); wdata = wd; start = 1'b1;
    t0 = cyc + 1;
    fall_cnt = 0; sdi_cap = '0; done_cyc = -1;
    tick();
    start = 1'b0;
    scramble();
  endtask

  task automatic settle();
    wait_to(t0 + frame_len() + 1);
  endtask

  task automatic do_reset_at(int off, bit with_start);
    wait_to(t0 + off);
    reset = 1'b1;
    if (with_start) begin
      start = 1'b1;
      scramble();
    end
    tick();
    reset = 1'b0;
    start = 1'b0;
    t0 = -1;
    pre_rdata = '0;
  endtask

  // Bring the bench to a point where the next launch is legal.
  task automatic to_next(int mode);
    int d;
    d = t0 + frame_len();
    if (mode == 0) wait_to(d + 1);
    else if (mode == 1) begin
      wait_to(d);
      start = 1'b1;
      scramble();
      tick();
    end else wait_to(d + 1 + $urandom_range(1, 5));
  endtask

  initial begin
    logic [DW-1:0] w;
    logic [DW-1:0] zero;
    zero = '0;
    reset = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; nbytes = '0; wdata = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk_en = 1'b1;
    chk_bit("reset_cs", CS, 1'b1);
    chk_bit("reset_spc", SPC, 1'b1);
    chk_bit("reset_sdi", SDI, 1'b0);
    chk_bit("reset_busy", busy, 1'b0);
    chk_vec("reset_rdata", rdata, zero);
    tick();

    // Single read of 0x0F, slave returns 0x33.
    launch(1'b1, 7'h0F, 1, zero, 1'b1, 8'h33);
    settle();
    chk_int("rd1_done_at", done_cyc - t0, 102);
    chk_int("rd1_falls", fall_cnt, 16);
    chk_int("rd1_cmd", int'(sdi_cap[15:8]), 'h8F);
    chk_vec("rd1_rdata", rdata, DW'('h33));

    // Write burst 0x97, 0x00, 0xFF to 0x20.
    w = '0; w[7:0] = 8'h97; w[15:8] = 8'h00; w[23:16] = 8'hFF;
    launch(1'b0, 7'h20, 3, w, 1'b0, 8'h00);
    settle();
    chk_int("wr3_done_at", done_cyc - t0, 198);
    chk_int("wr3_sdi", int'(sdi_cap[31:0]), 'h209700FF);
    chk_vec("wr3_rdata", rdata, zero);

    // Two-byte read.
    launch(1'b1, 7'h33, 2, zero, 1'b0, 8'h00);
    settle();
    chk_int("rd2_done_at", done_cyc - t0, 150);
    chk_int("rd2_falls", fall_cnt, 24);

    // Start while busy is ignored; reset at T0+20; restart one cycle later.
    launch(1'b1, 7'h11, 3, zero, 1'b0, 8'h00);
    wait_to(t0 + 10);
    start = 1'b1; rw = 1'b0; nbytes = '0;
    tick();
    start = 1'b0;
    do_reset_at(20, 1'b0);
    chk_bit("rst_cs", CS, 1'b1);
    chk_bit("rst_spc", SPC, 1'b1);
    chk_bit("rst_busy", busy, 1'b0);
    chk_vec("rst_rdata", rdata, zero);
    launch(1'b1, 7'h05, 2, zero, 1'b0, 8'h00);
    settle();
    chk_int("restart_done_at", done_cyc - t0, 150);

    // Reset with start in the same cycle, after some read bits were captured.
    launch(1'b1, 7'h44, 4, zero, 1'b1, 8'hFF);
    do_reset_at(70, 1'b1);
    chk_vec("rst2_rdata", rdata, zero);
    chk_bit("rst2_busy", busy, 1'b0);
    tick();

    // Command-only frame.
    launch(1'b0, 7'h7E, 0, zero, 1'b0, 8'h00);
    settle();
    chk_int("nb0_done_at", done_cyc - t0, 54);
    chk_int("nb0_falls", fall_cnt, 8);

    // Over-long request is clamped to MAX_BYTES.
    for (int k = 0; k < MAXB; k++) w[8*k +: 8] = 8'($urandom);
    launch(1'b0, 7'h01, 15, w, 1'b0, 8'h00);
    settle();
    chk_int("nb15_falls", fall_cnt, 104);
    chk_int("nb15_done_at", done_cyc - t0, 630);

    // Command byte with and without the auto-increment flag; these launches are back-to-back.
    launch(1'b1, 7'h28, 6, zero, 1'b0, 8'h00);
    settle();
`ifdef SPI_BURST_MS_BIT_EN
    chk_int("cmd_nb6", int'(sdi_cap[55:48]), 'hE8);
`else
    chk_int("cmd_nb6", int'(sdi_cap[55:48]), 'hA8);
`endif
    launch(1'b1, 7'h28, 1, zero, 1'b0, 8'h00);
    settle();
    chk_int("cmd_nb1", int'(sdi_cap[15:8]), 'hA8);
    chk_int("b2b_done_at", done_cyc - t0, 102);

    // Random frames with random spacing and stray start pulses.
    for (int it = 0; it < 20; it++) begin
      if (it > 0) to_next(int'($urandom_range(0, 3)));
      for (int k = 0; k < MAXB; k++) w[8*k +: 8] = 8'($urandom);
      launch(1'($urandom), 7'($urandom), int'($urandom_range(0, 15)), w, 1'b0, 8'h00);
      if ($urandom_range(0, 1) == 1) begin
        wait_to(t0 + int'($urandom_range(1, frame_len() - 1)));
        start = 1'b1;
        scramble();
        tick();
        start = 1'b0;
      end
    end
    settle();
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/spi_burst_master.md
# spi_burst_master

Parametrised SPI mode-3 master for register-mapped sensors: one command byte (R/W flag plus address) followed by a run-time-selectable burst of 0..MAX_BYTES data bytes, read or write. SPC rate is set by a clock divider. It sits between the sensor-polling controller and the off-chip SPI pins. It replaces the fixed single-byte and fixed-length read masters with one block.

## Interface
Parameters:
- MAX_BYTES, 12: maximum data bytes per frame; ≥1.
- CLK_DIV, 1: SPC half-period in clk cycles (H); ≥1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  request a frame; accepted only when busy=0.
- rw  in  1  1=read, 0=write; latched on accept.
- addr  in  7  register address; latched on accept.
- nbytes  in  $clog2(MAX_BYTES+1)  data bytes in the frame; latched on accept.
- wdata  in  8*MAX_BYTES  write bytes; byte k at [8k+7:8k]; latched on accept.
- SDO  in  1  serial data from the slave.
- SPC  out  1  serial clock; idles high.
- CS  out  1  chip select, active-low.
- SDI  out  1  serial data to the slave.
- rdata  out  8*MAX_BYTES  read bytes; byte k at [8k+7:8k].
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at frame end.

## Operation
- All outputs are registered.
- Reset values: CS=1, SPC=1, SDI=0, busy=0, done=0, rdata=0.
- FSM states: IDLE → SETUP → SHIFT → HOLD → DONE → IDLE.
- Accept: start=1 while in IDLE. On accept, latch rw, addr, wdata and eff_n = min(nbytes, MAX_BYTES), clear rdata to 0, set busy=1. start is ignored in every other state.
- Command byte: {rw, addr[6:0]}, MSB first. See Configuration for the variant.
- Frame length: N = 8*(1+eff_n) bits. eff_n=0 sends the command byte only.
- SETUP: CS=0, SPC=1 for H cycles.
- SHIFT, for each bit: SPC=0 for H cycles, then SPC=1 for H cycles.
  - SDI takes the bit's value on the edge that drives SPC low.
  - Command bits come from the command byte.
  - Data bits come from wdata byte k, MSB first, when rw=0; SDI=0 when rw=1.
- Sampling: when rw=1, on the edge that drives SPC high during data bit j of byte k, SDO is stored into rdata[8k+7-j]. Command-phase SDO is discarded. Write frames leave rdata=0.
- HOLD: CS=0, SPC=1, SDI=0 for H cycles.
- DONE: CS=1, done=1, busy=1 for exactly one cycle, then IDLE (busy=0). A start on the cycle after DONE is accepted.
- rdata holds its value from DONE until the next accept.
- Internal counters: a phase counter 0..H-1 and a bit counter 0..N-1. Both wrap with no gaps between bits or bytes.

## Timing
- Accept edge = T0. CS falls and busy rises at T0.
- First SPC fall at T0+H. Bit i falls at T0+H+2iH and rises at T0+2H+2iH.
- done=1 during the cycle starting at T0+(2N+2)H. CS returns high on that same edge.
- Examples: CLK_DIV=1, nbytes=1 → done at T0+34. CLK_DIV=3, nbytes=2 → done at T0+150.
- Reset mid-frame:
  - The next edge forces the reset values and IDLE.
  - No done pulse; partial rdata is cleared.
  - Reset has priority over start in the same cycle.
- nbytes > MAX_BYTES is clamped to MAX_BYTES. Inputs changing after accept have no effect on the frame.

## Configuration
- SPI_BURST_MS_BIT_EN defined:
  - Command byte = {rw, ms, addr[5:0]}, where ms = (eff_n > 1), i.e. the slave's address auto-increment flag.
  - addr[6] is ignored.
- Undefined: command byte = {rw, addr[6:0]}; no auto-increment flag is sent.

## Test plan
- Single read, CLK_DIV=1, rw=1, addr=0x0F, nbytes=1, slave returns 0x33 → SDI command bits 1,0,0,0,1,1,1,1; rdata[7:0]=0x33; upper rdata=0; done at T0+34; exactly 16 SPC falls.
- Write burst, rw=0, addr=0x20, nbytes=3, wdata bytes 0x97, 0x00, 0xFF → SDI shows 0x20, 0x97, 0x00, 0xFF MSB-first on SPC falls; rdata stays 0; done at T0+66.
- Divider, CLK_DIV=3, read with nbytes=2 → every SPC phase lasts 3 cycles; done at T0+150; SDO bits sampled only on rising SPC edges.
- Reset and busy:
  - start pulsed at T0+10 while busy → ignored; frame unaffected.
  - reset at T0+20 → next edge CS=1, SPC=1, busy=0, rdata=0, no done.
  - A start 1 cycle later is accepted normally.
- Boundaries:
  - nbytes=0 → 8 SPC pulses; done at T0+18 (CLK_DIV=1).
  - nbytes=15 with MAX_BYTES=12 → exactly 104 bits.
  - Back-to-back start immediately after done → accepted.
- Macro: with SPI_BURST_MS_BIT_EN, read of addr=0x28 with nbytes=6 → command byte 0xE8. With nbytes=1 → 0xA8.
